// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and instruction-fetch sequencer: issues one imem request per
// instruction, waits for the response with a timeout, and hands the result to decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_seq_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic        drop;
  logic [7:0]  wait_cnt;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      drop          <= 1'b0;
      wait_cnt      <= '0;
      pc_o          <= RESET_PC;
      imem_req_o    <= 1'b0;
      imem_addr_o   <= '0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      misalign_o    <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      imem_req_o <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      if (redirect_i) begin
        pc_o          <= redirect_tgt;
        misalign_o    <= |redirect_pc_i[1:0];
        instr_valid_o <= 1'b0;
        case (state)
          // Request to the old PC is already on the bus; its response must be thrown away.
          REQ: begin
            state    <= WAIT;
            drop     <= 1'b1;
            wait_cnt <= '0;
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              drop        <= 1'b0;
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= redirect_tgt;
            end else begin
              drop <= 1'b1;
            end
          end
          default: begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= redirect_tgt;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc_o;
          end
          REQ: begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              if (drop) begin
                drop        <= 1'b0;
                state       <= REQ;
                imem_req_o  <= 1'b1;
                imem_addr_o <= pc_o;
              end else begin
                instr_o       <= imem_rdata_i;
                instr_pc_o    <= pc_o;
                instr_valid_o <= 1'b1;
                state         <= OUT;
              end
            end else if (wait_cnt >= LAST_WAIT) begin
              // Lost response: refetch whatever pc_o currently holds.
              timeout_o   <= 1'b1;
              drop        <= 1'b0;
              state       <= REQ;
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc_o;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          OUT: begin
            if (instr_ready_i) begin
              instr_valid_o <= 1'b0;
              pc_o          <= pc_seq_i;
              state         <= REQ;
              imem_req_o    <= 1'b1;
              imem_addr_o   <= pc_seq_i;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: a bench-side imem with random latency plus a
// transaction-level reference model of the fetch sequencer.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;
  localparam int          N_CYCLES = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_seq;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        instr_valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        misalign;
  logic        timeout;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_seq_i     (pc_seq),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .instr_valid_o(instr_valid),
    .instr_ready_i(ready),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc),
    .pc_o         (pc),
    .misalign_o   (misalign),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what the fetcher owes the outside world, in transaction terms.
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  bit          m_req, m_valid, m_mis, m_to;
  bit          m_boot;      // one bubble still owed after reset
  bit          m_inflight;  // a request is outstanding
  bit          m_stale;     // outstanding request belongs to a superseded PC
  int          m_age;       // cycles spent waiting for the outstanding response

  // Bench-side instruction memory
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  task automatic model_reset();
    m_pc = RESET_PC; m_addr = '0; m_instr = '0; m_ipc = '0;
    m_req = 0; m_valid = 0; m_mis = 0; m_to = 0;
    m_boot = 1; m_inflight = 0; m_stale = 0; m_age = 0;
  endtask

  task automatic issue(input logic [31:0] a);
    m_req  = 1;
    m_addr = a;
  endtask

  task automatic model_step();
    bit          req0, boot0, busy0, valid0;
    logic [31:0] tgt;
    req0 = m_req; boot0 = m_boot; busy0 = m_inflight; valid0 = m_valid;
    tgt  = {redirect_pc[31:2], 2'b00};
    m_req = 0; m_mis = 0; m_to = 0;
    if (redirect) begin
      m_pc    = tgt;
      m_mis   = (redirect_pc[1:0] != 2'b00);
      m_valid = 0;
      m_boot  = 0;
      if (req0) begin
        m_inflight = 1; m_age = 0; m_stale = 1;
      end else if (busy0) begin
        if (rvalid) begin
          m_inflight = 0; m_stale = 0; issue(tgt);
        end else begin
          m_stale = 1;
        end
      end else begin
        issue(tgt);
      end
    end else if (boot0) begin
      m_boot = 0;
      issue(m_pc);
    end else if (req0) begin
      m_inflight = 1; m_age = 0;
    end else if (busy0) begin
      if (rvalid) begin
        m_inflight = 0;
        if (m_stale) begin
          m_stale = 0; issue(m_pc);
        end else begin
          m_valid = 1; m_instr = rdata; m_ipc = m_pc;
        end
      end else if (m_age + 1 == MAX_WAIT) begin
        m_to = 1; m_stale = 0; m_inflight = 0; issue(m_pc);
      end else begin
        m_age++;
      end
    end else if (valid0 && ready) begin
      $display("fetch accepted pc=%h instr=%h", m_ipc, m_instr);
      m_valid = 0;
      m_pc    = m_pc + 32'd4;
      issue(m_pc);
    end
  endtask

  task automatic compare();
    check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
    check("pc", pc, m_pc);
    if (m_req) check("imem_addr", imem_addr, m_addr);
    if (m_valid) begin
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
    end
  endtask

  task automatic drive();
    int sel;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (mem_cnt == 1) begin
      rvalid  = 1'b1;
      rdata   = mem_addr ^ 32'h5A5A_C3C3;
      mem_cnt = 0;
    end else begin
      if (mem_cnt > 1) mem_cnt--;
      rvalid = ($urandom_range(0, 15) == 0);  // stray responses
    end
    if (imem_req) begin
      mem_addr = imem_addr;
      mem_cnt  = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 4));
    end
    redirect = ($urandom_range(0, 15) == 0);
    sel = int'($urandom_range(0, 3));
    if (sel == 0)      redirect_pc = $urandom & 32'h0000_0FFF;
    else if (sel == 1) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
    else               redirect_pc = $urandom;
    ready  = ($urandom_range(0, 2) != 0);
    pc_seq = m_pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0; rvalid = 1'b0; ready = 1'b0;
    model_reset();
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    repeat (2) @(negedge clk);
    compare();
    // Release with a late response from before reset on the bus; it must be ignored.
    rst      = 1'b0;
    rvalid   = 1'b1;
    rdata    = 32'hDEAD_BEEF;
    redirect = 1'b0;
    ready    = 1'b1;
    pc_seq   = m_pc + 32'd4;
    mem_cnt  = 0;
    model_step();
  endtask

  initial begin
    redirect = 1'b0; redirect_pc = '0; rvalid = 1'b0; rdata = '0;
    ready = 1'b0; pc_seq = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      compare();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive();
        model_step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
